// File: rtl/multi_rate_fifo.sv
// -----------------------------------------------------------------------------
// multi_rate_fifo
//   Circular FIFO whose push and pop strides differ. Each accepted push stores
//   WR_N elements and each accepted pop removes RD_N elements. Read data is
//   first-word-fall-through: the oldest RD_N elements are always presented
//   combinationally on rd_data.
//
// Parameters
//   DATA_W  element width in bits
//   DEPTH   storage in elements (power of two, >= 2)
//   WR_N    elements per push (1..DEPTH)
//   RD_N    elements per pop  (1..DEPTH)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset (pointers and count only)
//   wr_en        push request
//   wr_data      push payload, element 0 in the LSBs
//   wr_ready     room for one push (count + WR_N <= DEPTH)
//   rd_en        pop request
//   rd_data      oldest RD_N elements, oldest in the LSBs
//   rd_valid     one pop available (count >= RD_N)
//   full/empty   count == DEPTH / count == 0
//   count        occupancy in elements
//   wr_overflow  sticky: push attempted while !wr_ready   (MULTI_RATE_FIFO_ERR_EN)
//   rd_underflow sticky: pop attempted while !rd_valid    (MULTI_RATE_FIFO_ERR_EN)
//
// Optional build macro: MULTI_RATE_FIFO_ERR_EN adds the two sticky error ports.
// -----------------------------------------------------------------------------
module multi_rate_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int WR_N   = 4,
  parameter int RD_N   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WR_N*DATA_W-1:0]     wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  output logic [RD_N*DATA_W-1:0]     rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef MULTI_RATE_FIFO_ERR_EN
  ,
  output logic                       wr_overflow,
  output logic                       rd_underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CW-1:0]     w_count_next;
  logic [AW-1:0]     w_waddr [WR_N];
  logic [AW-1:0]     w_raddr [RD_N];

  // Flags depend on the registered count only, so they fall immediately
  // to their reset values when rst asserts.
  // Comparing against DEPTH-WR_N avoids widening the sum count+WR_N.
  assign wr_ready = (r_count <= CW'(DEPTH - WR_N));
  assign rd_valid = (r_count >= CW'(RD_N));
  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;

  assign w_wr_acc = wr_en && wr_ready;
  assign w_rd_acc = rd_en && rd_valid;

  // DEPTH is a power of two, so AW-bit address arithmetic wraps naturally.
  generate
    for (genvar gi = 0; gi < WR_N; gi++) begin : g_waddr
      assign w_waddr[gi] = r_wptr + AW'(gi);
    end
    for (genvar gi = 0; gi < RD_N; gi++) begin : g_rdata
      assign w_raddr[gi] = r_rptr + AW'(gi);
      assign rd_data[gi*DATA_W +: DATA_W] = r_mem[w_raddr[gi]];
    end
  endgenerate

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc) w_count_next = w_count_next + CW'(WR_N);
    if (w_rd_acc) w_count_next = w_count_next - CW'(RD_N);
  end

  // Storage has no reset; a push only ever targets free slots, so it cannot
  // collide with slots being popped in the same cycle.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int i = 0; i < WR_N; i++) begin
        r_mem[w_waddr[i]] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(WR_N);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(RD_N);
      r_count <= w_count_next;
    end
  end

`ifdef MULTI_RATE_FIFO_ERR_EN
  logic r_wr_overflow;
  logic r_rd_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_overflow  <= 1'b0;
      r_rd_underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ready) r_wr_overflow  <= 1'b1;
      if (rd_en && !rd_valid) r_rd_underflow <= 1'b1;
    end
  end

  assign wr_overflow  = r_wr_overflow;
  assign rd_underflow = r_rd_underflow;
`endif

endmodule

// File: tb/tb_multi_rate_fifo.sv
// -----------------------------------------------------------------------------
// tb_multi_rate_fifo
//   Directed bench for multi_rate_fifo (DATA_W=8, DEPTH=16, WR_N=4, RD_N=2).
//   Stimulus enqueues the expected 16-bit pop words for every accepted push;
//   an independent monitor pops and compares them whenever a pop is taken.
// -----------------------------------------------------------------------------
module tb_multi_rate_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int WR_N   = 4;
  localparam int RD_N   = 2;

  logic                   clk;
  logic                   rst;
  logic                   wr_en;
  logic [WR_N*DATA_W-1:0] wr_data;
  logic                   wr_ready;
  logic                   rd_en;
  logic [RD_N*DATA_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   full;
  logic                   empty;
  logic [4:0]             count;
`ifdef MULTI_RATE_FIFO_ERR_EN
  logic                   wr_overflow;
  logic                   rd_underflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q [$];

  multi_rate_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .WR_N(WR_N), .RD_N(RD_N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count)
`ifdef MULTI_RATE_FIFO_ERR_EN
    ,
    .wr_overflow  (wr_overflow),
    .rd_underflow (rd_underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: a pop is taken at the next rising edge whenever rd_en && rd_valid
  // are seen here; the presented word must be the oldest expected one.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rd_en && rd_valid) begin
        if (exp_q.size() == 0) begin
          check("pop_without_expected", 32'(rd_data), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", 32'(rd_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted push: the two 16-bit pop words it will produce, element 0 lowest.
  task automatic push(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w[15:0]);
    exp_q.push_back(w[31:16]);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_flags(input string tag);
    check({tag, "_count"},    32'(count),    32'd0);
    check({tag, "_empty"},    32'(empty),    32'd1);
    check({tag, "_full"},     32'(full),     32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
`ifdef MULTI_RATE_FIFO_ERR_EN
    check({tag, "_wr_overflow"},  32'(wr_overflow),  32'd0);
    check({tag, "_rd_underflow"}, 32'(rd_underflow), 32'd0);
`endif
  endtask

  // Asserts rst between edges and checks flags before any clock edge.
  task automatic mid_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_reset_flags(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // 1: reset asserted before the first clock edge
    #2;
    rst = 1'b1;
    #1;
    check_reset_flags("t1_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2: single push, two pops
    push(32'h03020100);
    check("t2_count4",   32'(count),    32'd4);
    check("t2_rd_valid", 32'(rd_valid), 32'd1);
    check("t2_rd_data",  32'(rd_data),  32'h0100);
    pop(1);
    check("t2_count2",   32'(count),    32'd2);
    check("t2_rd_data2", 32'(rd_data),  32'h0302);
    pop(1);
    check("t2_count0",   32'(count),    32'd0);
    check("t2_empty",    32'(empty),    32'd1);

    // 3: fill from a fresh reset, then a rejected push
    mid_reset("t3_rst");
    push(32'h23222120);
    push(32'h27262524);
    push(32'h2B2A2928);
    push(32'h2F2E2D2C);
    check("t3_count16",  32'(count),    32'd16);
    check("t3_full",     32'(full),     32'd1);
    check("t3_wr_ready", 32'(wr_ready), 32'd0);
    wr_en = 1'b1; wr_data = 32'hFFFFFFFF;
    tick();
    wr_en = 1'b0;
    check("t3_count_hold", 32'(count),   32'd16);
    check("t3_head_kept",  32'(rd_data), 32'h2120);
`ifdef MULTI_RATE_FIFO_ERR_EN
    check("t3_wr_overflow", 32'(wr_overflow), 32'd1);
`endif

    // 4: pop twice, push that wraps into slots 0..3
    pop(2);
    check("t4_count12", 32'(count), 32'd12);
    push(32'h13121110);
    check("t4_count16", 32'(count), 32'd16);
    pop(2);
    check("t5_count12", 32'(count), 32'd12);

    // 5: simultaneous push and pop at count 12
    wr_en = 1'b1; wr_data = 32'h17161514; rd_en = 1'b1;
    exp_q.push_back(16'h1514);
    exp_q.push_back(16'h1716);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("t5_count14",   32'(count),    32'd14);
    check("t5_wr_ready0", 32'(wr_ready), 32'd0);
    check("t5_rd_valid",  32'(rd_valid), 32'd1);

    // drain 14 elements, then one pop attempt on an empty FIFO
    rd_en = 1'b1;
    repeat (7) tick();
    check("t4_drained_count", 32'(count), 32'd0);
    check("t4_drained_empty", 32'(empty), 32'd1);
    tick();
    rd_en = 1'b0;
    check("t6_underflow_count", 32'(count), 32'd0);
`ifdef MULTI_RATE_FIFO_ERR_EN
    check("t6_rd_underflow", 32'(rd_underflow), 32'd1);
`endif
    check("t4_all_popped", 32'(exp_q.size()), 32'd0);

    // 6: push once, pop twice, third pop ignored
    push(32'h43424140);
    pop(2);
    check("t6_count0", 32'(count), 32'd0);
    pop(1);
    check("t6_count0_again", 32'(count), 32'd0);

    // reach count 10, then reset between edges
    push(32'h53525150);
    push(32'h57565554);
    push(32'h5B5A5958);
    pop(1);
    check("t6_count10", 32'(count), 32'd10);
    mid_reset("t6_rst");

    // operation resumes after reset
    push(32'hA3A2A1A0);
    check("t6_resume_data", 32'(rd_data), 32'hA1A0);
    pop(2);
    check("t6_resume_count", 32'(count), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_rate_fifo.md
Name: multi_rate_fifo

Overview:
- Parametrised circular FIFO with independent write and read widths.
- Each push stores WR_N elements; each pop removes RD_N elements.
- Successor to the fixed-stride pointer/comparator FIFO datapath: adds generic data/depth/stride parameters, an occupancy counter, valid/ready-style flags and first-word-fall-through read data.
- Sits between a wide producer and a narrower (or wider) consumer in the accelerator datapath.

Parameters:
- DATA_W, 8: element width in bits.
- DEPTH, 16: storage in elements. Must be a power of two and at least 2.
- WR_N, 4: elements written per accepted push. 1 <= WR_N <= DEPTH.
- RD_N, 2: elements read per accepted pop. 1 <= RD_N <= DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  push request.
- wr_data  input  WR_N*DATA_W  push payload; element 0 in the LSBs.
- wr_ready  output  1  space for one push: count + WR_N <= DEPTH.
- rd_en  input  1  pop request.
- rd_data  output  RD_N*DATA_W  oldest RD_N elements; element 0 (oldest) in the LSBs.
- rd_valid  output  1  one pop available: count >= RD_N.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy in elements.

Behaviour:
- State: wptr and rptr (each $clog2(DEPTH) bits, wrap modulo DEPTH), count register, and a DEPTH x DATA_W memory.
- Reset: while rst is high, asynchronously wptr=0, rptr=0, count=0. Memory is not reset.
  - Outputs during reset: empty=1, full=0, rd_valid=0, wr_ready=1 (since WR_N <= DEPTH); rd_data is don't-care.
- Push accepted (wr_acc) when wr_en && wr_ready.
  - Element i is written to mem[(wptr+i) mod DEPTH] for i = 0..WR_N-1.
  - wptr advances by WR_N modulo DEPTH.
- Pop accepted (rd_acc) when rd_en && rd_valid.
  - rptr advances by RD_N modulo DEPTH.
- rd_data is combinational: rd_data[i] = mem[(rptr+i) mod DEPTH]. Zero read latency (FWFT).
  - Pushed data is visible on rd_data the cycle after the push edge.
- Flags wr_ready, rd_valid, full and empty are combinational functions of count only. They never depend on the current-cycle wr_en/rd_en.
- Count update: next count = count + (wr_acc ? WR_N : 0) - (rd_acc ? RD_N : 0).
  - Computed at width $clog2(DEPTH)+1; can never overflow or underflow.
- Simultaneous push and pop:
  - Both are qualified against the pre-edge count.
  - The push never overwrites slots being popped, because it writes only free slots.
- Rejected requests are ignored: no state change, no data loss.
  - wr_en while !wr_ready.
  - rd_en while !rd_valid.
- Wrap-around:
  - Pointer additions are mod DEPTH.
  - A push or pop straddling the end of memory splits correctly across the boundary (e.g. wptr=14, WR_N=4 writes slots 14, 15, 0, 1).
- Partial occupancy: if 0 < count < RD_N, then empty=0 and rd_valid=0. The data is retained until enough elements arrive.
- Reset mid-operation: flags update immediately on rst assertion, without a clock edge. Operation resumes on the first rising edge after deassertion.

Optional Feature:
- Macro: MULTI_RATE_FIFO_ERR_EN.
- Defined: adds output ports wr_overflow (1 bit) and rd_underflow (1 bit). Both are sticky registers, reset to 0 asynchronously by rst.
  - wr_overflow sets on a clock edge where wr_en && !wr_ready.
  - rd_underflow sets on a clock edge where rd_en && !rd_valid.
  - Cleared only by rst.
- Undefined: the ports and registers do not exist. Rejected requests are silently ignored.

Test Plan (DATA_W=8, DEPTH=16, WR_N=4, RD_N=2):
1. Assert rst mid-cycle -> immediately count=0, empty=1, full=0, rd_valid=0, wr_ready=1.
2. Push 0x03020100 -> next cycle count=4, rd_valid=1, rd_data=0x0100. Pop -> rd_data=0x0302, count=2. Pop -> count=0, empty=1.
3. Four pushes -> count=16, full=1, wr_ready=0. Fifth push (0xFFFFFFFF) -> count stays 16, stored data unchanged. With the macro defined, wr_overflow=1.
4. Fill to 16, pop twice (count=12), push 0x13121110 -> writes wrap to slots 0..3. Draining yields elements in strict push order, ending with 0x10, 0x11, 0x12, 0x13.
5. At count=12, assert wr_en and rd_en in the same cycle -> both accepted, count=14, oldest 2 elements removed. Next cycle wr_ready=0.
6. Push once, pop twice, third pop with count=0 -> third pop ignored, count stays 0. With the macro defined, rd_underflow=1. Assert rst at count=10 between edges -> count=0 and flags cleared without a clock edge.
